// File: rtl/xenos_pkg.sv
// Shared types and default parameters for the XENOS fault manager.
package xenos_pkg;

  localparam int NUM_CH_DEF     = 16;
  localparam int CH_W_DEF       = $clog2(NUM_CH_DEF);
  localparam int CODE_W_DEF     = 4;
  localparam int DEB_W_DEF      = 4;
  localparam int LOG_DEPTH_DEF  = 8;
  localparam int TS_W_DEF       = 16;
  localparam int ESC_CYCLES_DEF = 256;
  localparam int REC_CYCLES_DEF = 1024;

  // Escalation state; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    FAULT   = 2'd1,
    SAFE    = 2'd2,
    RECOVER = 2'd3
  } xenos_state_e;

  // Log entry layout at default widths. The top flattens the same
  // {ch, code, ts} order into a packed vector so it follows its parameters.
  typedef struct packed {
    logic [CH_W_DEF-1:0]   ch;
    logic [CODE_W_DEF-1:0] code;
    logic [TS_W_DEF-1:0]   ts;
  } log_entry_t;

endpackage

// File: rtl/xenos_evt_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and a flush input.
// Full + push + pop in one cycle is accepted: the pop frees the slot.
module xenos_evt_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  // Head is forced to zero when empty so stale storage never shows after reset.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and count update; a flush overrides push and pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    do_pop   = rd_en && !empty && !clear;
    do_push  = wr_en && (!full || do_pop) && !clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; validity comes from the pointers, which are.
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/xenos_fault_mgr.sv
// Fault aggregator: per-channel debounce, sticky latching with ack,
// lowest-index priority report, escalation FSM and timestamped event log.
module xenos_fault_mgr
  import xenos_pkg::*;
#(
  parameter  int NUM_CH     = NUM_CH_DEF,
  parameter  int CODE_W     = CODE_W_DEF,
  parameter  int DEB_W      = DEB_W_DEF,
  parameter  int LOG_DEPTH  = LOG_DEPTH_DEF,
  parameter  int TS_W       = TS_W_DEF,
  parameter  int ESC_CYCLES = ESC_CYCLES_DEF,
  parameter  int REC_CYCLES = REC_CYCLES_DEF,
  localparam int CH_W       = $clog2(NUM_CH),
  localparam int LCW        = $clog2(LOG_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_fault,
  input  logic [NUM_CH*CODE_W-1:0] ch_code,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [DEB_W-1:0]         deb_thresh,
  input  logic                     ack_valid,
  input  logic [CH_W-1:0]          ack_ch,
  input  logic                     log_rd_en,
  input  logic                     log_clear,
  output logic                     log_rd_valid,
  output logic [CH_W-1:0]          log_rd_ch,
  output logic [CODE_W-1:0]        log_rd_code,
  output logic [TS_W-1:0]          log_rd_ts,
  output logic [LCW-1:0]           log_count,
  output logic                     log_overflow,
  output logic [NUM_CH-1:0]        sticky,
  output logic                     fault_active,
  output logic [CH_W-1:0]          fault_channel,
  output logic [CODE_W-1:0]        fault_code,
  output logic [1:0]               state,
  output logic                     safe_mode,
  output logic                     recovery
);

  localparam int TMR_MAX = (ESC_CYCLES > REC_CYCLES) ? ESC_CYCLES : REC_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int ENT_W   = CH_W + CODE_W + TS_W;

  logic [NUM_CH-1:0][DEB_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0][CODE_W-1:0] code_lat_q, code_lat_d;
  logic [NUM_CH-1:0]             sticky_q, sticky_d, pend_q, pend_d, pend_clr, confirm;
  logic [CH_W-1:0]               fault_channel_q, fault_channel_d, push_ch;
  logic [CODE_W-1:0]             fault_code_q, fault_code_d, push_code;
  logic [TS_W-1:0]               ts_q, ts_d;
  logic [TMR_W-1:0]              timer_q, timer_d;
  logic                          log_overflow_q, log_overflow_d, push;
  logic [DEB_W-1:0]              thr;
  logic [ENT_W-1:0]              rd_entry;
  logic                          fifo_full, fifo_empty;
  xenos_state_e                  state_q, state_d;

  assign thr = (deb_thresh == '0) ? DEB_W'(1) : deb_thresh;

  // Debounce counters; confirm pulses once when a count first reaches the threshold.
  always_comb begin
    cnt_d   = cnt_q;
    confirm = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!ch_fault[i] || ch_mask[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < thr) begin
        cnt_d[i]   = cnt_q[i] + DEB_W'(1);
        confirm[i] = ((cnt_q[i] + DEB_W'(1)) == thr);
      end
    end
  end

  // Sticky/code latching (confirm beats ack), priority encode and log push selection.
  always_comb begin
    sticky_d        = sticky_q;
    code_lat_d      = code_lat_q;
    fault_channel_d = '0;
    fault_code_d    = '0;
    push            = 1'b0;
    push_ch         = '0;
    push_code       = '0;
    pend_clr        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ack_valid && ack_ch == CH_W'(i) && cnt_q[i] == '0) sticky_d[i] = 1'b0;
      if (confirm[i]) begin
        sticky_d[i]   = 1'b1;
        code_lat_d[i] = ch_code[i*CODE_W +: CODE_W];
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (sticky_d[i]) begin
        fault_channel_d = CH_W'(i);
        fault_code_d    = code_lat_d[i];
      end
      if (pend_q[i]) begin
        push        = 1'b1;
        push_ch     = CH_W'(i);
        push_code   = code_lat_q[i];
        pend_clr    = '0;
        pend_clr[i] = 1'b1;
      end
    end
    pend_d = (pend_q & ~pend_clr) | confirm;
  end

  // Overflow flag and free-running timestamp.
  always_comb begin
    ts_d           = ts_q + TS_W'(1);
    log_overflow_d = log_overflow_q;
    if (log_clear)                              log_overflow_d = 1'b0;
    else if (push && fifo_full && !log_rd_en)   log_overflow_d = 1'b1;
  end

  // Escalation FSM next state; the dwell timer restarts on every state change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL:  if (fault_active) state_d = FAULT;
      FAULT:   if (!fault_active) state_d = NORMAL;
               else if (timer_q == TMR_W'(ESC_CYCLES - 1)) state_d = SAFE;
      SAFE:    if (!fault_active) state_d = RECOVER;
      RECOVER: if (fault_active) state_d = SAFE;
               else if (timer_q == TMR_W'(REC_CYCLES - 1)) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
    timer_d = ((state_d == state_q) && (state_q == FAULT || state_q == RECOVER))
              ? timer_q + TMR_W'(1) : '0;
  end

  // FSM decoded outputs.
  always_comb begin
    state     = state_q;
    safe_mode = (state_q == SAFE);
    recovery  = (state_q == RECOVER);
  end

  // All block state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q           <= '0;
      code_lat_q      <= '0;
      sticky_q        <= '0;
      pend_q          <= '0;
      fault_channel_q <= '0;
      fault_code_q    <= '0;
      log_overflow_q  <= 1'b0;
      ts_q            <= '0;
      timer_q         <= '0;
      state_q         <= NORMAL;
    end else begin
      cnt_q           <= cnt_d;
      code_lat_q      <= code_lat_d;
      sticky_q        <= sticky_d;
      pend_q          <= pend_d;
      fault_channel_q <= fault_channel_d;
      fault_code_q    <= fault_code_d;
      log_overflow_q  <= log_overflow_d;
      ts_q            <= ts_d;
      timer_q         <= timer_d;
      state_q         <= state_d;
    end
  end

  xenos_evt_fifo #(.WIDTH(ENT_W), .DEPTH(LOG_DEPTH)) u_log (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (log_clear),
    .wr_en   (push),
    .wr_data ({push_ch, push_code, ts_q}),
    .rd_en   (log_rd_en),
    .rd_data (rd_entry),
    .count   (log_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign log_rd_valid  = !fifo_empty;
  assign {log_rd_ch, log_rd_code, log_rd_ts} = rd_entry;
  assign log_overflow  = log_overflow_q;
  assign sticky        = sticky_q;
  assign fault_active  = |sticky_q;
  assign fault_channel = fault_channel_q;
  assign fault_code    = fault_code_q;

endmodule

// File: tb/tb_xenos_fault_mgr.sv
// Directed bench for xenos_fault_mgr at default parameters.
module tb_xenos_fault_mgr;

  localparam int NUM_CH = 16;
  localparam int CODE_W = 4;
  localparam int CH_W   = 4;
  localparam int TS_W   = 16;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        ch_fault, ch_mask, sticky;
  logic [NUM_CH*CODE_W-1:0] ch_code;
  logic [3:0]               deb_thresh;
  logic                     ack_valid, log_rd_en, log_clear;
  logic [CH_W-1:0]          ack_ch, log_rd_ch, fault_channel;
  logic                     log_rd_valid, log_overflow, fault_active, safe_mode, recovery;
  logic [CODE_W-1:0]        log_rd_code, fault_code;
  logic [TS_W-1:0]          log_rd_ts;
  logic [3:0]               log_count;
  logic [1:0]               state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ts_a, ts_b;

  xenos_fault_mgr dut (
    .clk(clk), .rst_n(rst_n), .ch_fault(ch_fault), .ch_code(ch_code), .ch_mask(ch_mask),
    .deb_thresh(deb_thresh), .ack_valid(ack_valid), .ack_ch(ack_ch), .log_rd_en(log_rd_en),
    .log_clear(log_clear), .log_rd_valid(log_rd_valid), .log_rd_ch(log_rd_ch),
    .log_rd_code(log_rd_code), .log_rd_ts(log_rd_ts), .log_count(log_count),
    .log_overflow(log_overflow), .sticky(sticky), .fault_active(fault_active),
    .fault_channel(fault_channel), .fault_code(fault_code), .state(state),
    .safe_mode(safe_mode), .recovery(recovery)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are read 1 time unit after the edge. ts in the DUT equals cyc.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ack(input int ch);
    ack_valid = 1'b1;
    ack_ch    = CH_W'(ch);
    tick();
    ack_valid = 1'b0;
  endtask

  task automatic pop();
    log_rd_en = 1'b1;
    tick();
    log_rd_en = 1'b0;
  endtask

  task automatic check_head(input string tag, input int ch, input int code, input int ts);
    check({tag, "_valid"}, 32'(log_rd_valid), 1);
    check({tag, "_ch"},    32'(log_rd_ch),    32'(ch));
    check({tag, "_code"},  32'(log_rd_code),  32'(code));
    check({tag, "_ts"},    32'(log_rd_ts),    32'(ts));
  endtask

  initial begin
    rst_n = 1'b0; ch_fault = '0; ch_mask = '0; ch_code = '0; deb_thresh = 4'd3;
    ack_valid = 1'b0; ack_ch = '0; log_rd_en = 1'b0; log_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    // Reset state
    check("rst_state",  32'(state), 0);
    check("rst_sticky", 32'(sticky), 0);
    check("rst_count",  32'(log_count), 0);
    check("rst_valid",  32'(log_rd_valid), 0);

    // Short pulse on ch5 (2 cycles, threshold 3) must not confirm
    ch_code[5*CODE_W +: CODE_W] = 4'hA;
    ch_fault[5] = 1'b1;
    repeat (2) tick();
    ch_fault[5] = 1'b0;
    repeat (2) tick();
    check("short_sticky", 32'(sticky), 0);
    check("short_count",  32'(log_count), 0);

    // Three cycles confirm ch5; masked ch4 never confirms
    ch_fault[5] = 1'b1; ch_fault[4] = 1'b1; ch_mask[4] = 1'b1;
    repeat (3) tick();
    check("c5_sticky", 32'(sticky), 32'h0020);
    check("c5_fch",    32'(fault_channel), 5);
    check("c5_fcode",  32'(fault_code), 32'hA);
    ts_a = cyc;
    ch_fault[4] = 1'b0; ch_mask[4] = 1'b0;
    tick();
    check("c5_state", 32'(state), 1);
    check("c5_count", 32'(log_count), 1);
    check_head("c5_head", 5, 'hA, ts_a);
    ch_fault[5] = 1'b0;
    pop();
    check("c5_pop_count", 32'(log_count), 0);
    ack(5);
    check("c5_ack_sticky", 32'(sticky), 0);
    check("c5_ack_fch",    32'(fault_channel), 0);
    tick();
    check("c5_state_norm", 32'(state), 0);

    // Ch2 and ch9 confirm together
    ch_code[2*CODE_W +: CODE_W] = 4'h3;
    ch_code[9*CODE_W +: CODE_W] = 4'h7;
    ch_fault[2] = 1'b1; ch_fault[9] = 1'b1;
    repeat (3) tick();
    check("dual_sticky", 32'(sticky), 32'h0204);
    check("dual_fch",    32'(fault_channel), 2);
    check("dual_fcode",  32'(fault_code), 3);
    ts_a = cyc;
    tick();
    check("dual_count1", 32'(log_count), 1);
    tick();
    check("dual_count2", 32'(log_count), 2);
    check_head("dual_head0", 2, 3, ts_a);
    pop();
    check_head("dual_head1", 9, 7, ts_a + 1);
    pop();
    check("dual_empty", 32'(log_rd_valid), 0);

    // Ack while the fault is still asserted is ignored
    ack(2);
    check("ack_busy_sticky", 32'(sticky), 32'h0204);
    check("ack_busy_fch",    32'(fault_channel), 2);
    ch_fault[2] = 1'b0;
    tick();
    ack(2);
    check("ack2_fch",   32'(fault_channel), 9);
    check("ack2_fcode", 32'(fault_code), 7);
    ch_fault[9] = 1'b0;
    tick();
    ack(9);
    check("ack9_active", 32'(fault_active), 0);
    tick();
    check("ack9_state", 32'(state), 0);

    // Threshold 0 acts as 1; confirm beats a same-cycle ack
    deb_thresh = 4'd0;
    ch_code[3*CODE_W +: CODE_W] = 4'h6;
    ch_fault[3] = 1'b1;
    ack(3);
    check("conf_vs_ack", 32'(sticky), 32'h0008);
    tick();
    check("esc_fault", 32'(state), 1);
    repeat (255) tick();
    check("esc_255", 32'(state), 1);
    tick();
    check("esc_256",  32'(state), 2);
    check("esc_safe", 32'(safe_mode), 1);

    // Clear -> RECOVER; new fault -> SAFE; clear again; 1024 quiet cycles -> NORMAL
    ch_fault[3] = 1'b0;
    tick();
    ack(3);
    tick();
    check("rec_enter", 32'(state), 3);
    check("rec_flag",  32'(recovery), 1);
    ch_fault[3] = 1'b1;
    tick();
    tick();
    check("rec_refault", 32'(state), 2);
    ch_fault[3] = 1'b0;
    tick();
    ack(3);
    tick();
    check("rec_enter2", 32'(state), 3);
    repeat (1023) tick();
    check("rec_1023", 32'(state), 3);
    tick();
    check("rec_1024", 32'(state), 0);

    // Overflow: flush, then ch0..8 confirm together (9 events into 8 slots)
    log_clear = 1'b1;
    tick();
    log_clear = 1'b0;
    check("clr0_count", 32'(log_count), 0);
    for (int i = 0; i < 10; i++) ch_code[i*CODE_W +: CODE_W] = CODE_W'(i + 1);
    ch_fault[8:0] = 9'h1FF;
    tick();
    ts_a = cyc;
    repeat (10) tick();
    check("ovf_count", 32'(log_count), 8);
    check("ovf_flag",  32'(log_overflow), 1);
    check_head("ovf_head", 0, 1, ts_a);

    // Tenth confirm (ch9) pushes in the same cycle as a pop while full
    ch_fault[9] = 1'b1;
    tick();
    pop();
    check("fullrw_count", 32'(log_count), 8);
    check_head("fullrw_head", 1, 2, ts_a + 1);
    pop();
    check_head("fullrw_head2", 2, 3, ts_a + 2);

    log_clear = 1'b1;
    tick();
    log_clear = 1'b0;
    check("clr_count", 32'(log_count), 0);
    check("clr_ovf",   32'(log_overflow), 0);
    check("clr_valid", 32'(log_rd_valid), 0);

    // Refill with fresh episodes on ch0..7, then hold until SAFE
    ch_fault[7:0] = 8'h00;
    tick();
    ch_fault[7:0] = 8'hFF;
    tick();
    ts_b = cyc;
    begin : wait_safe
      int k;
      k = 0;
      while (!safe_mode && k < 400) begin
        tick();
        k++;
      end
    end
    check("fill_safe",  32'(safe_mode), 1);
    check("fill_count", 32'(log_count), 8);
    check_head("fill_head", 0, 1, ts_b);

    // Asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    check("mrst_state",   32'(state), 0);
    check("mrst_safe",    32'(safe_mode), 0);
    check("mrst_sticky",  32'(sticky), 0);
    check("mrst_active",  32'(fault_active), 0);
    check("mrst_fch",     32'(fault_channel), 0);
    check("mrst_fcode",   32'(fault_code), 0);
    check("mrst_count",   32'(log_count), 0);
    check("mrst_valid",   32'(log_rd_valid), 0);
    check("mrst_ovf",     32'(log_overflow), 0);
    check("mrst_head",    32'({log_rd_ch, log_rd_code, log_rd_ts}), 0);
    ch_fault = '0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_state", 32'(state), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
